// File: rtl/gb_bus_pkg.sv
// Shared types and constants for the Game Boy CPU bus, OAM DMA and bus arbitration.
package gb_bus_pkg;

  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;
  typedef enum logic [1:0] {RD_MEM, RD_REG, RD_FF} rdsrc_t;

  localparam logic [15:0] OAM_BASE        = 16'hFE00;
  localparam int          OAM_LEN         = 160;
  localparam logic [15:0] DMA_REG_DEFAULT = 16'hFF46;
  localparam logic [7:0]  ECHO_LO         = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET     = 8'h20;

  // Echo RAM E000-FDFF mirrors C000-DDFF, so DMA sources from those pages fold down.
  function automatic logic [7:0] src_page(input logic [7:0] page);
    return (page >= ECHO_LO) ? page - ECHO_OFFSET : page;
  endfunction

endpackage

// File: rtl/gb_bus_mux.sv
// Shared memory bus owner select (CPU or DMA) and the registered CPU read-return path.
module gb_bus_mux
  import gb_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  input  logic        dma_own,
  input  logic        dma_rd,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  page_reg,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  cpu_rdata
);

  logic       cpu_mem;
  logic       is_reg;
  rdsrc_t     rdsrc_p1;
  logic [7:0] reg_p1;

  assign cpu_mem = (cpu_addr < OAM_BASE);
  assign is_reg  = (cpu_addr == DMA_REG_ADDR);

  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    if (!reset) begin
      if (dma_own) begin
        if (dma_rd) begin
          mem_addr = dma_addr;
          mem_rd   = 1'b1;
        end
      end else if (cpu_mem) begin
        mem_addr  = cpu_addr;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_wdata = cpu_wdata;
      end
    end
  end

  // Return stage: remember where the read came from; memory data arrives by itself one clock later.
  always_ff @(posedge clk) begin
    if (reset || !cpu_rd) begin
      rdsrc_p1 <= RD_FF;
    end else if (is_reg) begin
      rdsrc_p1 <= RD_REG;
    end else if (cpu_mem && !dma_own) begin
      rdsrc_p1 <= RD_MEM;
    end else begin
      rdsrc_p1 <= RD_FF;
    end
  end

  always_ff @(posedge clk) begin
    reg_p1 <= page_reg;
  end

  always_comb begin
    case (rdsrc_p1)
      RD_MEM:  cpu_rdata = mem_rdata;
      RD_REG:  cpu_rdata = reg_p1;
      default: cpu_rdata = 8'hFF;
    endcase
  end

endmodule

// File: rtl/gb_oam_dma.sv
// OAM DMA controller: FF46 write copies 160 bytes from page XX00 into OAM while owning the memory bus.
module gb_oam_dma
  import gb_bus_pkg::*;
#(
  parameter int          BYTE_CYCLES  = 4,
  parameter int          START_DELAY  = 1,
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  localparam int              PH_W     = $clog2(BYTE_CYCLES);
  localparam int              DLY_W    = (START_DELAY < 2) ? 1 : $clog2(START_DELAY + 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(BYTE_CYCLES - 1);
  localparam logic [7:0]      IDX_LAST = 8'(OAM_LEN - 1);

  dma_state_t       state, state_n;
  logic [DLY_W-1:0] dly, dly_n;
  logic [7:0]       index, index_n;
  logic [PH_W-1:0]  phase, phase_n;
  logic [7:0]       page_reg, page_n;
  logic [7:0]       byte_p1;
  logic             reg_wr;
  logic             xfer;
  logic             dma_rd;
  logic [15:0]      dma_addr;

  assign reg_wr = cpu_wr && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dly      <= '0;
      index    <= '0;
      phase    <= '0;
      page_reg <= 8'h00;
    end else begin
      state    <= state_n;
      dly      <= dly_n;
      index    <= index_n;
      phase    <= phase_n;
      page_reg <= page_n;
    end
  end

  always_comb begin
    state_n = state;
    dly_n   = dly;
    index_n = index;
    phase_n = phase;
    page_n  = page_reg;
    case (state)
      START: begin
        if (dly <= DLY_W'(1)) begin
          state_n = XFER;
          index_n = '0;
          phase_n = '0;
        end else begin
          dly_n = dly - DLY_W'(1);
        end
      end
      XFER: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          if (index == IDX_LAST) begin
            state_n = IDLE;
          end else begin
            index_n = index + 8'd1;
          end
        end else begin
          phase_n = phase + PH_W'(1);
        end
      end
      default: ;
    endcase
    // A register write starts or restarts the copy from any state; a partial byte is dropped.
    if (reg_wr) begin
      page_n  = cpu_wdata;
      index_n = '0;
      phase_n = '0;
      dly_n   = DLY_W'(START_DELAY);
      state_n = (START_DELAY == 0) ? XFER : START;
    end
  end

  // Byte buffer stage: source data returns one clock after the phase-0 read.
  always_ff @(posedge clk) begin
    if (state == XFER && phase == PH_W'(1)) begin
      byte_p1 <= mem_rdata;
    end
  end

  assign xfer       = !reset && (state == XFER);
  assign dma_rd     = xfer && (phase == '0);
  assign dma_addr   = {src_page(page_reg), index};
  assign oam_wr     = xfer && (phase == PH_W'(2));
  assign oam_addr   = oam_wr ? index : '0;
  assign oam_wdata  = oam_wr ? byte_p1 : '0;
  assign dma_active = !reset && (state != IDLE);

  gb_bus_mux #(
    .DMA_REG_ADDR(DMA_REG_ADDR)
  ) u_mux (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_rd   (cpu_rd),
    .cpu_wr   (cpu_wr),
    .cpu_wdata(cpu_wdata),
    .dma_own  (dma_active),
    .dma_rd   (dma_rd),
    .dma_addr (dma_addr),
    .page_reg (page_reg),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_wdata(mem_wdata),
    .cpu_rdata(cpu_rdata)
  );

endmodule

// File: tb/tb_gb_oam_dma.sv
// Self-checking bench for gb_oam_dma: behavioural memory, event logs and a page-copy reference model.
module tb_gb_oam_dma;

  localparam int LOGN = 4096;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] cpu_addr  = '0;
  logic        cpu_rd    = 1'b0;
  logic        cpu_wr    = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  oam_addr;
  logic        oam_wr;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  mem [0:65535];
  int          oam_n = 0;
  logic [7:0]  oam_la [LOGN];
  logic [7:0]  oam_ld [LOGN];
  int          oam_lc [LOGN];
  int          rd_n = 0;
  logic [15:0] rd_la [LOGN];
  int          rd_lc [LOGN];
  int          wr_n = 0;
  logic [15:0] wr_la [LOGN];

  always #5 clk = ~clk;

  gb_oam_dma dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .oam_addr  (oam_addr),
    .oam_wr    (oam_wr),
    .oam_wdata (oam_wdata),
    .dma_active(dma_active)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (oam_wr && oam_n < LOGN) begin
      oam_la[oam_n] <= oam_addr;
      oam_ld[oam_n] <= oam_wdata;
      oam_lc[oam_n] <= cyc;
      oam_n <= oam_n + 1;
    end
    if (mem_rd && rd_n < LOGN) begin
      rd_la[rd_n] <= mem_addr;
      rd_lc[rd_n] <= cyc;
      rd_n <= rd_n + 1;
    end
    if (mem_wr && wr_n < LOGN) begin
      wr_la[wr_n] <= mem_addr;
      wr_n <= wr_n + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // Source byte address for OAM index i when the DMA register holds page.
  function automatic logic [15:0] ref_src(input logic [7:0] page, input int i);
    int base;
    base = int'(page) * 256;
    if (base >= 'hE000) base = base - 'h2000;
    return 16'(base + i);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int w);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    tick();
    cpu_wr = 1'b0;
    w = cyc;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    tick();
    cpu_rd = 1'b0;
    d = cpu_rdata;
  endtask

  task automatic wait_done(input int budget, output int fall);
    fall = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (!dma_active) begin
        fall = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || oam_wr !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes got rd=%b wr=%b oam_wr=%b want 0 0 0", mem_rd, mem_wr, oam_wr);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dma_active !== 1'b0) begin
      failures++;
      $display("FAIL reset_active got %b want 0", dma_active);
    end
    checks++;
    if (cpu_rdata !== 8'hFF) begin
      failures++;
      $display("FAIL reset_rdata got %h want ff", cpu_rdata);
    end
    checks++;
    if (oam_addr !== 8'h00 || oam_wdata !== 8'h00 || mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_buses got oam_addr=%h oam_wdata=%h mem_addr=%h mem_wdata=%h want zeros",
               oam_addr, oam_wdata, mem_addr, mem_wdata);
    end
    cpu_read(16'hFF46, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL reset_reg got %h want 00", d);
    end
  endtask

  task automatic test_passthrough;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  wd;
    for (int n = 0; n < 4; n++) begin
      a = (n == 0) ? 16'h0150 : 16'($urandom_range(0, 'hFDFF));
      cpu_addr = a;
      cpu_rd   = 1'b1;
      #1;
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== a) begin
        failures++;
        $display("FAIL pass_rd_req got rd=%b addr=%h want 1 %h", mem_rd, mem_addr, a);
      end
      tick();
      cpu_rd = 1'b0;
      checks++;
      if (cpu_rdata !== mem[a]) begin
        failures++;
        $display("FAIL pass_rdata addr=%h got %h want %h", a, cpu_rdata, mem[a]);
      end
    end
    a  = 16'($urandom_range(0, 'hFDFF));
    wd = 8'($urandom);
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_wr    = 1'b1;
    #1;
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== a || mem_wdata !== wd) begin
      failures++;
      $display("FAIL pass_wr got wr=%b addr=%h data=%h want 1 %h %h", mem_wr, mem_addr, mem_wdata, a, wd);
    end
    tick();
    cpu_wr = 1'b0;
    cpu_addr = 16'hFF80;
    cpu_rd   = 1'b1;
    #1;
    checks++;
    if (mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL pass_hi_rd got mem_rd=%b want 0", mem_rd);
    end
    tick();
    cpu_rd = 1'b0;
    d = cpu_rdata;
    checks++;
    if (d !== 8'hFF) begin
      failures++;
      $display("FAIL pass_hi_rdata got %h want ff", d);
    end
  endtask

  task automatic test_basic_copy;
    int w, fall, o0, r0;
    for (int i = 0; i < 160; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
    o0 = oam_n;
    r0 = rd_n;
    cpu_write(16'hFF46, 8'hC0, w);
    wait_done(800, fall);
    checks++;
    if (fall != w + 641) begin
      failures++;
      $display("FAIL basic_duration got fall_cyc=%0d want %0d", fall, w + 641);
    end
    checks++;
    if (rd_la[r0] !== 16'hC000 || rd_lc[r0] != w + 1) begin
      failures++;
      $display("FAIL basic_first_rd got addr=%h cyc=%0d want c000 %0d", rd_la[r0], rd_lc[r0], w + 1);
    end
    checks++;
    if (oam_n - o0 != 160) begin
      failures++;
      $display("FAIL basic_count got %0d want 160", oam_n - o0);
    end else begin
      for (int i = 0; i < 160; i++) begin
        checks++;
        if (oam_la[o0 + i] !== 8'(i) || oam_ld[o0 + i] !== (8'(i) ^ 8'h5A)) begin
          failures++;
          $display("FAIL basic_oam[%0d] got addr=%h data=%h want %h %h",
                   i, oam_la[o0 + i], oam_ld[o0 + i], 8'(i), 8'(i) ^ 8'h5A);
        end
      end
      checks++;
      if (oam_lc[o0 + 159] >= fall) begin
        failures++;
        $display("FAIL basic_last_before_fall got wr_cyc=%0d fall_cyc=%0d", oam_lc[o0 + 159], fall);
      end
    end
  endtask

  task automatic test_cpu_blocking;
    int w, fall, o0, r0, w0, hits;
    logic [7:0] p;
    logic [7:0] d;
    p  = 8'($urandom_range('hC1, 'hDF));
    o0 = oam_n;
    r0 = rd_n;
    w0 = wr_n;
    cpu_write(16'hFF46, p, w);
    repeat (5) tick();
    cpu_read(16'h8000, d);
    checks++;
    if (d !== 8'hFF) begin
      failures++;
      $display("FAIL block_rdata got %h want ff", d);
    end
    cpu_write(16'hC010, 8'h77, fall);
    wait_done(800, fall);
    checks++;
    if (fall < 0) begin
      failures++;
      $display("FAIL block_timeout got no end of transfer want end within 800 clocks");
    end
    hits = 0;
    for (int k = r0; k < rd_n; k++) if (rd_la[k] == 16'h8000) hits++;
    checks++;
    if (hits != 0) begin
      failures++;
      $display("FAIL block_no_8000 got %0d reads want 0", hits);
    end
    checks++;
    if (wr_n != w0) begin
      failures++;
      $display("FAIL block_no_wr got %0d writes want 0", wr_n - w0);
    end
    checks++;
    if (oam_n - o0 != 160) begin
      failures++;
      $display("FAIL block_count got %0d want 160", oam_n - o0);
    end else begin
      for (int i = 0; i < 160; i++) begin
        checks++;
        if (oam_la[o0 + i] !== 8'(i) || oam_ld[o0 + i] !== mem[ref_src(p, i)]) begin
          failures++;
          $display("FAIL block_oam[%0d] got addr=%h data=%h want %h %h",
                   i, oam_la[o0 + i], oam_ld[o0 + i], 8'(i), mem[ref_src(p, i)]);
        end
      end
    end
    cpu_read(16'h8000, d);
    checks++;
    if (d !== mem[16'h8000]) begin
      failures++;
      $display("FAIL block_after_rd got %h want %h", d, mem[16'h8000]);
    end
  endtask

  task automatic test_echo;
    int w, fall, o0, r0;
    logic [7:0] p;
    for (int n = 0; n < 2; n++) begin
      p  = (n == 0) ? 8'hE1 : 8'($urandom_range('hE0, 'hFF));
      o0 = oam_n;
      r0 = rd_n;
      cpu_write(16'hFF46, p, w);
      wait_done(800, fall);
      checks++;
      if (rd_n - r0 != 160) begin
        failures++;
        $display("FAIL echo_reads page=%h got %0d want 160", p, rd_n - r0);
      end else begin
        checks++;
        if (rd_la[r0] !== ref_src(p, 0) || rd_la[r0 + 159] !== ref_src(p, 159)) begin
          failures++;
          $display("FAIL echo_addr page=%h got first=%h last=%h want %h %h",
                   p, rd_la[r0], rd_la[r0 + 159], ref_src(p, 0), ref_src(p, 159));
        end
      end
      checks++;
      if (oam_n - o0 != 160) begin
        failures++;
        $display("FAIL echo_count page=%h got %0d want 160", p, oam_n - o0);
      end else begin
        for (int i = 0; i < 160; i++) begin
          checks++;
          if (oam_ld[o0 + i] !== mem[ref_src(p, i)]) begin
            failures++;
            $display("FAIL echo_oam[%0d] page=%h got %h want %h", i, p, oam_ld[o0 + i], mem[ref_src(p, i)]);
          end
        end
      end
    end
  endtask

  task automatic test_restart;
    int w1, w2, fall, o0, r0, j, drops, first;
    o0 = oam_n;
    r0 = rd_n;
    drops = 0;
    cpu_write(16'hFF46, 8'hC0, w1);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!dma_active) drops++;
    end
    cpu_write(16'hFF46, 8'hD0, w2);
    checks++;
    if (drops != 0 || !dma_active) begin
      failures++;
      $display("FAIL restart_active got %0d low clocks want 0", drops);
    end
    wait_done(800, fall);
    checks++;
    if (fall != w2 + 641) begin
      failures++;
      $display("FAIL restart_duration got fall_cyc=%0d want %0d", fall, w2 + 641);
    end
    first = -1;
    for (int k = r0; k < rd_n; k++) begin
      if (first < 0 && rd_lc[k] >= w2) first = k;
    end
    checks++;
    if (first < 0 || rd_la[first] !== 16'hD000 || rd_lc[first] != w2 + 1) begin
      failures++;
      $display("FAIL restart_first_rd got idx=%0d addr=%h want d000 at cyc %0d",
               first, (first < 0) ? 16'h0 : rd_la[first], w2 + 1);
    end
    j = 0;
    for (int k = o0; k < oam_n; k++) begin
      if (oam_lc[k] >= w2) begin
        checks++;
        if (oam_la[k] !== 8'(j) || oam_ld[k] !== mem[ref_src(8'hD0, j)]) begin
          failures++;
          $display("FAIL restart_oam[%0d] got addr=%h data=%h want %h %h",
                   j, oam_la[k], oam_ld[k], 8'(j), mem[ref_src(8'hD0, j)]);
        end
        j++;
      end
    end
    checks++;
    if (j != 160) begin
      failures++;
      $display("FAIL restart_count got %0d want 160", j);
    end
  endtask

  task automatic test_reg_reset;
    int w, o0, o1, r1, k;
    logic [7:0] d;
    o0 = oam_n;
    cpu_write(16'hFF46, 8'h3A, w);
    repeat (7) tick();
    cpu_read(16'hFF46, d);
    checks++;
    if (d !== 8'h3A) begin
      failures++;
      $display("FAIL reg_readback got %h want 3a", d);
    end
    k = 0;
    while (oam_n - o0 < 50 && k < 400) begin
      tick();
      k++;
    end
    checks++;
    if (oam_n - o0 != 50) begin
      failures++;
      $display("FAIL reg_reach50 got %0d writes want 50", oam_n - o0);
    end
    reset = 1'b1;
    o1 = oam_n;
    tick();
    reset = 1'b0;
    r1 = rd_n;
    checks++;
    if (dma_active !== 1'b0) begin
      failures++;
      $display("FAIL reg_reset_active got %b want 0", dma_active);
    end
    repeat (20) tick();
    checks++;
    if (oam_n != o1) begin
      failures++;
      $display("FAIL reg_reset_no_oam got %0d extra writes want 0", oam_n - o1);
    end
    checks++;
    if (rd_n != r1) begin
      failures++;
      $display("FAIL reg_reset_no_rd got %0d extra reads want 0", rd_n - r1);
    end
    cpu_read(16'hFF46, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL reg_after_reset got %h want 00", d);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_passthrough();
    test_basic_copy();
    test_cpu_blocking();
    test_echo();
    test_restart();
    test_reg_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
